uart_rx_monitor: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/fifo_v3.sv | 61 ++++++
 rtl/uart_rx_monitor.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and helpers for the UART receive monitor
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // Rounded to the nearest integer so odd clock/baud ratios stay centred
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return (clk_freq_hz + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO with head-of-queue data output and occupancy count
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0] rd_ptr;
  logic [ADDR_DEPTH-1:0] wr_ptr;
  logic [ADDR_DEPTH:0]   status_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  stored_empty;
  logic                  do_push;
  logic                  do_pop;
  logic                  bypass;

  assign stored_empty = (status_cnt == '0);
  assign full_o       = (status_cnt == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o      = stored_empty & ~(FALL_THROUGH & push_i);
  assign usage_o      = status_cnt[ADDR_DEPTH-1:0];
  assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign bypass  = FALL_THROUGH & stored_empty & do_push & do_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      status_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      status_cnt <= '0;
    end else begin
      if (do_push && !bypass) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop && !bypass) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) status_cnt <= status_cnt + 1'b1;
      else if (do_pop && !do_push) status_cnt <= status_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - oversampling UART receiver feeding a byte FIFO with error flags
module uart_rx_monitor
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY_EN   = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = $clog2(CPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);

  logic          rx_meta;
  logic          rxs;
  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_err_pend;
  logic          bit_done;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] fifo_usage;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign bit_done = (cnt == BIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_err_pend <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      if (!rx_en_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!rxs) state <= START;
          end
          START: begin
            if (cnt == HALF_LAST) begin
              cnt <= '0;
              if (rxs) begin
                state <= IDLE;
              end else begin
                state        <= DATA;
                bit_idx      <= '0;
                par_err_pend <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_done) begin
              cnt     <= '0;
              shreg   <= {rxs, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (bit_done) begin
              cnt          <= '0;
              par_err_pend <= (rxs != ^shreg);
              state        <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_done) begin
              cnt <= '0;
              if (!rxs) begin
                frame_err_o <= 1'b1;
                state       <= BREAK;
              end else begin
                parity_err_o <= par_err_pend;
                state        <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BREAK: begin
            cnt <= '0;
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Pushed on the stop-sample edge itself so valid_o rises the following cycle
  assign push = rx_en_i && (state == STOP) && bit_done && rxs && !par_err_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_o <= 1'b0;
    else if (push && fifo_full && !ready_i) overflow_o <= 1'b1;
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (8),
    .DEPTH        (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (shreg),
    .push_i  (push),
    .data_o  (data_o),
    .pop_i   (ready_i)
  );

  assign valid_o = ~fifo_empty;
  assign count_o = {fifo_full, fifo_usage};

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - directed bench for the UART receive monitor
module tb_uart_rx_monitor;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic       sel_p;
  logic       rx_en;
  logic       ready;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
  logic [4:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int vcyc_a, vcyc_b, fe_n_a, fe_n_b, pe_n_a, pe_n_b;

  assign rx_a = sel_p ? 1'b1 : rx_line;
  assign rx_b = sel_p ? rx_line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .CLK_FREQ_HZ (1152000), .BAUD_RATE (115200), .PARITY_EN (0), .FIFO_DEPTH (16)
  ) dut (
    .clk_i (clk), .rst_i (rst), .rx_i (rx_a), .rx_en_i (rx_en),
    .data_o (data_a), .valid_o (valid_a), .ready_i (ready),
    .frame_err_o (fe_a), .parity_err_o (pe_a), .overflow_o (ov_a), .count_o (cnt_a)
  );

  uart_rx_monitor #(
    .CLK_FREQ_HZ (1152000), .BAUD_RATE (115200), .PARITY_EN (1), .FIFO_DEPTH (16)
  ) dut_p (
    .clk_i (clk), .rst_i (rst), .rx_i (rx_b), .rx_en_i (rx_en),
    .data_o (data_b), .valid_o (valid_b), .ready_i (ready),
    .frame_err_o (fe_b), .parity_err_o (pe_b), .overflow_o (ov_b), .count_o (cnt_b)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a) vcyc_a++;
      if (valid_b) vcyc_b++;
      if (valid_a && ready) got_a.push_back(data_a);
      if (valid_b && ready) got_b.push_back(data_b);
      if (fe_a) fe_n_a++;
      if (fe_b) fe_n_b++;
      if (pe_a) pe_n_a++;
      if (pe_b) pe_n_b++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_a.delete();
    got_b.delete();
    vcyc_a = 0; vcyc_b = 0;
    fe_n_a = 0; fe_n_b = 0;
    pe_n_a = 0; pe_n_b = 0;
  endtask

  task automatic hold_bits(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after a rising edge; stop sample lands 8 edges into the stop bit
  task automatic send(input logic [7:0] d, input bit use_par, input bit par,
                      input int stop_low, input bit pulse_ready);
    rx_line = 1'b0;
    hold_bits(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      hold_bits(CPB);
    end
    if (use_par) begin
      rx_line = par;
      hold_bits(CPB);
    end
    if (stop_low > 0) begin
      rx_line = 1'b0;
      hold_bits(stop_low);
      rx_line = 1'b1;
    end else if (pulse_ready) begin
      rx_line = 1'b1;
      hold_bits(7);
      ready = 1'b1;
      hold_bits(1);
      ready = 1'b0;
      hold_bits(2);
    end else begin
      rx_line = 1'b1;
      hold_bits(CPB);
    end
    hold_bits(4);
  endtask

  function automatic int head(input logic [7:0] q[$], input int idx);
    return (idx < q.size()) ? int'(q[idx]) : -1;
  endfunction

  initial begin
    rst = 1'b1; rx_line = 1'b1; sel_p = 1'b0; rx_en = 1'b1; ready = 1'b1;
    clear_mon();
    hold_bits(3);
    check("reset_valid", valid_a, 0);
    check("reset_count", cnt_a, 0);
    check("reset_data", data_a, 0);
    check("reset_errs", {fe_a, pe_a, ov_a}, 0);
    rst = 1'b0;
    hold_bits(3);

    // Single character
    clear_mon();
    send(8'h41, 0, 0, 0, 0);
    hold_bits(5);
    check("c41_valid_cycles", vcyc_a, 1);
    check("c41_data", head(got_a, 0), 8'h41);
    check("c41_fe", fe_n_a, 0);
    check("c41_pe", pe_n_a, 0);
    check("c41_count", cnt_a, 0);

    // Short low glitch is rejected, next frame still decodes
    clear_mon();
    rx_line = 1'b0;
    hold_bits(3);
    rx_line = 1'b1;
    hold_bits(30);
    check("glitch_valid", vcyc_a, 0);
    check("glitch_fe", fe_n_a, 0);
    send(8'h5A, 0, 0, 0, 0);
    hold_bits(5);
    check("post_glitch_data", head(got_a, 0), 8'h5A);

    // Stop bit held low: one frame error, then recovery
    clear_mon();
    send(8'h55, 0, 0, 30, 0);
    hold_bits(20);
    check("break_fe", fe_n_a, 1);
    check("break_valid", vcyc_a, 0);
    send(8'h0A, 0, 0, 0, 0);
    hold_bits(5);
    check("after_break_n", got_a.size(), 1);
    check("after_break_data", head(got_a, 0), 8'h0A);
    check("after_break_fe", fe_n_a, 1);

    // Even parity on the second instance
    sel_p = 1'b1;
    clear_mon();
    send(8'h03, 1, 1, 0, 0);
    hold_bits(5);
    check("par_bad_pe", pe_n_b, 1);
    check("par_bad_valid", vcyc_b, 0);
    check("par_bad_fe", fe_n_b, 0);
    send(8'h03, 1, 0, 0, 0);
    hold_bits(5);
    check("par_good_n", got_b.size(), 1);
    check("par_good_data", head(got_b, 0), 8'h03);
    check("par_good_pe", pe_n_b, 1);
    check("par_idle_a", vcyc_a, 0);
    sel_p = 1'b0;

    // Overflow: 17 bytes into a 16-entry buffer
    clear_mon();
    ready = 1'b0;
    for (int k = 0; k < 17; k++) send(8'(k), 0, 0, 0, 0);
    check("ovf_count", cnt_a, 16);
    check("ovf_flag", ov_a, 1);
    check("ovf_head", data_a, 8'h00);
    ready = 1'b1;
    hold_bits(20);
    check("ovf_pop_n", got_a.size(), 16);
    for (int k = 0; k < 16; k++) check($sformatf("ovf_pop_%0d", k), head(got_a, k), k);
    check("ovf_drained", cnt_a, 0);
    check("ovf_sticky", ov_a, 1);

    // Push on a full buffer with a same-cycle pop
    rst = 1'b1;
    hold_bits(1);
    rst = 1'b0;
    check("ovf_cleared", ov_a, 0);
    ready = 1'b0;
    hold_bits(2);
    clear_mon();
    for (int k = 0; k < 16; k++) send(8'(8'h30 + k), 0, 0, 0, 0);
    check("full_count", cnt_a, 16);
    check("full_no_ovf", ov_a, 0);
    send(8'h40, 0, 0, 0, 1);
    check("pushpop_count", cnt_a, 16);
    check("pushpop_no_ovf", ov_a, 0);
    ready = 1'b1;
    hold_bits(25);
    check("pushpop_n", got_a.size(), 17);
    for (int k = 0; k < 17; k++) check($sformatf("pushpop_%0d", k), head(got_a, k), 8'h30 + k);

    // Reset in the middle of a frame with buffered data
    ready = 1'b0;
    clear_mon();
    send(8'h11, 0, 0, 0, 0);
    check("pre_rst_count", cnt_a, 1);
    rx_line = 1'b0;
    hold_bits(CPB);
    rx_line = 1'b1;
    hold_bits(4 * CPB + 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", valid_a, 0);
    check("async_rst_count", cnt_a, 0);
    check("async_rst_data", data_a, 0);
    check("async_rst_errs", {fe_a, pe_a, ov_a}, 0);
    hold_bits(2);
    rst = 1'b0;
    clear_mon();
    ready = 1'b1;
    hold_bits(200);
    check("post_rst_valid", vcyc_a, 0);
    check("post_rst_fe", fe_n_a, 0);
    check("post_rst_count", cnt_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
